// File: rtl/seg_disp_sched.sv
// Two-digit time-multiplexed display scheduler: stores the two most recent hex keys
// and alternates the shared segment decoder between digits with a blanking gap at every switch.
module seg_disp_sched #(
  parameter int DWELL_CYCLES = 60000,
  parameter int BLANK_CYCLES = 240,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  output logic       key_ready,
  output logic [3:0] value,
  output logic [1:0] anodes,
  output logic [3:0] digit_old,
  output logic [3:0] digit_new
);

  typedef enum logic [1:0] {
    BLANK_R = 2'd0,
    SHOW_L  = 2'd1,
    BLANK_L = 2'd2,
    SHOW_R  = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             phase_end_s;
  logic             enter_blank_r_s;
  logic             enter_blank_l_s;
  logic [1:0]       anodes_nxt_s;
  logic             pending_r;
  logic [3:0]       pend_r;

  // Phase sequencing and next-cycle anode pattern.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r + CNT_W'(1);
    phase_end_s  = 1'b0;
    anodes_nxt_s = 2'b11;
    case (state_r)
      BLANK_R, BLANK_L: phase_end_s = (cnt_r == CNT_W'(BLANK_CYCLES - 1));
      SHOW_L, SHOW_R:   phase_end_s = (cnt_r == CNT_W'(DWELL_CYCLES - 1));
      default:          phase_end_s = 1'b1;
    endcase
    if (phase_end_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      case (state_r)
        BLANK_R: state_nxt_s = SHOW_L;
        SHOW_L:  state_nxt_s = BLANK_L;
        BLANK_L: state_nxt_s = SHOW_R;
        SHOW_R:  state_nxt_s = BLANK_R;
        default: state_nxt_s = BLANK_R;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    // Anodes follow the state being entered, so a digit is never lit across a switch.
    case (state_nxt_s)
      SHOW_L:  anodes_nxt_s = 2'b10;
      SHOW_R:  anodes_nxt_s = 2'b01;
      default: anodes_nxt_s = 2'b11;
    endcase
  end

  assign enter_blank_r_s = phase_end_s && (state_r == SHOW_R);
  assign enter_blank_l_s = phase_end_s && (state_r == SHOW_L);

  // State and phase counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= BLANK_R;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Registered anodes and the decoder value, preloaded at each blank entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anodes <= 2'b11;
      value  <= 4'h0;
    end else begin
      anodes <= anodes_nxt_s;
      if (enter_blank_r_s) begin
        // A commit on this edge shifts digit_new into digit_old; show the shifted value.
        value <= pending_r ? digit_new : digit_old;
      end else if (enter_blank_l_s) begin
        value <= digit_new;
      end else begin
        value <= value;
      end
    end
  end

  // One-entry key buffer; digits only shift at the start of a frame to avoid tearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= 1'b0;
      pend_r    <= 4'h0;
      key_ready <= 1'b1;
      digit_old <= 4'h0;
      digit_new <= 4'h0;
    end else if (enter_blank_r_s && pending_r) begin
      digit_old <= digit_new;
      digit_new <= pend_r;
      pending_r <= 1'b0;
      key_ready <= 1'b1;
    end else if (key_valid && key_ready) begin
      pend_r    <= key_val;
      pending_r <= 1'b1;
      key_ready <= 1'b0;
    end else begin
      pending_r <= pending_r;
      pend_r    <= pend_r;
      key_ready <= key_ready;
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Scoreboard bench for seg_disp_sched: a frame-position model predicts every cycle's outputs,
// a separate monitor pops and compares them, and display invariants are checked each cycle.
module tb_seg_disp_sched;
  localparam int D = 4;
  localparam int B = 2;
  localparam int F = 2 * (D + B);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_val = 4'h0;
  logic       key_ready;
  logic [3:0] value;
  logic [1:0] anodes;
  logic [3:0] digit_old;
  logic [3:0] digit_new;

  always #5 clk = ~clk;

  seg_disp_sched #(.DWELL_CYCLES(D), .BLANK_CYCLES(B), .CNT_W(17)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_val(key_val),
    .key_ready(key_ready), .value(value), .anodes(anodes),
    .digit_old(digit_old), .digit_new(digit_new)
  );

  typedef struct packed {
    logic [1:0] an;
    logic [3:0] val;
    logic [3:0] d_old;
    logic [3:0] d_new;
    logic       rdy;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Model: cycle index since reset release, frame position, and the key/digit history.
  int         c = 0;
  bit         m_pend_v = 1'b0;
  logic [3:0] m_pend = 4'h0;
  logic [3:0] m_old = 4'h0;
  logic [3:0] m_new = 4'h0;

  function automatic exp_t predict();
    exp_t e;
    int   p;
    p = c % F;
    if (p < B)              e.an = 2'b11;
    else if (p < B + D)     e.an = 2'b10;
    else if (p < 2 * B + D) e.an = 2'b11;
    else                    e.an = 2'b01;
    e.val   = (p < B + D) ? m_old : m_new;
    e.d_old = m_old;
    e.d_new = m_new;
    e.rdy   = !m_pend_v;
    e.cyc   = c;
    return e;
  endfunction

  // One clock of stimulus: drive at negedge, advance the model, queue the expected outputs.
  task automatic step(input bit kv, input logic [3:0] kval, input bit rst_low, input bit async_pulse);
    bit was_pend;
    @(negedge clk);
    key_valid = kv;
    key_val   = kval;
    if (async_pulse) begin
      #2 reset = 1'b0;
      #1;
      checks++;
      if (anodes !== 2'b11 || digit_old !== 4'h0 || digit_new !== 4'h0 || key_ready !== 1'b1) begin
        failures++;
        $display("FAIL async_reset: got an=%b old=%h new=%h rdy=%b, want an=11 old=0 new=0 rdy=1",
                 anodes, digit_old, digit_new, key_ready);
      end
    end else begin
      reset = rst_low ? 1'b0 : 1'b1;
    end
    if (!reset) begin
      c = 0; m_pend_v = 1'b0; m_pend = 4'h0; m_old = 4'h0; m_new = 4'h0;
    end else begin
      was_pend = m_pend_v;
      c++;
      if ((c % F) == 0 && was_pend) begin
        m_old = m_new;
        m_new = m_pend;
        m_pend_v = 1'b0;
      end else if (kv && !was_pend) begin
        m_pend = kval;
        m_pend_v = 1'b1;
      end
    end
    exp_q.push_back(predict());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0);
  endtask

  task automatic to_phase(input int p);
    for (int i = 0; i < F && (c % F) != p; i++) idle(1);
  endtask

  // Monitor: compare queued expectations and check display invariants just after each edge.
  initial begin
    exp_t       e;
    logic [3:0] prev_value = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (anodes !== e.an || value !== e.val || digit_old !== e.d_old ||
            digit_new !== e.d_new || key_ready !== e.rdy) begin
          failures++;
          $display("FAIL outputs c=%0d: got an=%b val=%h old=%h new=%h rdy=%b, want an=%b val=%h old=%h new=%h rdy=%b",
                   e.cyc, anodes, value, digit_old, digit_new, key_ready,
                   e.an, e.val, e.d_old, e.d_new, e.rdy);
        end
      end
      checks++;
      if (anodes === 2'b00) begin
        failures++;
        $display("FAIL anodes_overlap: got an=%b, want not 00", anodes);
      end
      if (value !== prev_value) begin
        checks++;
        if (anodes !== 2'b11) begin
          failures++;
          $display("FAIL value_tearing: value %h->%h with an=%b, want an=11", prev_value, value, anodes);
        end
      end
      prev_value = value;
    end
  end

  initial begin
    // Reset release and one idle frame sequence.
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    idle(2 * F);
    // Key mid-SHOW_L.
    to_phase(3); key(4'h5); idle(2 * F);
    // Two keys in separate frames.
    to_phase(3); key(4'h3); idle(F);
    to_phase(4); key(4'hA); idle(2 * F);
    // Second key while not ready is dropped.
    to_phase(3); key(4'h7); key(4'h9); idle(2 * F);
    // Key on the edge that enters BLANK_R.
    to_phase(F - 1); key(4'hC); idle(2 * F + 2);
    // Reset during SHOW_R with digits 3/A and a pending key.
    to_phase(3); key(4'h3); idle(F);
    to_phase(3); key(4'hA); idle(F);
    to_phase(3); key(4'h6);
    to_phase(9);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    idle(2 * F);
    // Randomized key traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
